// File: rtl/control_contador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_contador_pkg
// Description : Shared state encoding, datapath width, button indices and
//               clear > load > step arbitration for the button-driven counter.
// Revision    : 1.0 - initial release
// ============================================================================
package control_contador_pkg;

    localparam int C_ANCHO = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ESPERA = 2'd1,
        ST_REPITE = 2'd2
    } estado_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Higher value wins when several requests arrive in the same cycle
    localparam logic [1:0] C_PRIO_NADA = 2'd0;
    localparam logic [1:0] C_PRIO_PASO = 2'd1;
    localparam logic [1:0] C_PRIO_LOAD = 2'd2;
    localparam logic [1:0] C_PRIO_CLR  = 2'd3;

    localparam int C_BTN_UP   = 0;
    localparam int C_BTN_DOWN = 1;
    localparam int C_BTN_CLR  = 2;
    localparam int C_BTN_LOAD = 3;
    localparam int C_NUM_BTN  = 4;

    function automatic logic [1:0] f_arbitra(input logic clr, input logic load, input logic paso);
        if (clr)
            return C_PRIO_CLR;
        else if (load)
            return C_PRIO_LOAD;
        else if (paso)
            return C_PRIO_PASO;
        else
            return C_PRIO_NADA;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_contador_sync.sv
`default_nettype none
// ============================================================================
// Module      : flanco_sync
// Description : Two-flop synchronizer with synchronized level and a
//               registered one-cycle rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module flanco_sync (
    input  logic iClk,
    input  logic iReset_n,
    input  logic iBoton,
    output logic oNivel,
    output logic oFlanco
);

    logic r_meta;
    logic r_sinc;
    logic r_prev;
    logic r_flanco;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_meta   <= 1'b0;
            r_sinc   <= 1'b0;
            r_prev   <= 1'b0;
            r_flanco <= 1'b0;
        end else begin
            r_meta   <= iBoton;
            r_sinc   <= r_meta;
            r_prev   <= r_sinc;
            r_flanco <= r_sinc & ~r_prev;
        end
    end

    assign oNivel  = r_sinc;
    assign oFlanco = r_flanco;

endmodule
`default_nettype wire

// File: rtl/control_contador.sv
`default_nettype none
// ============================================================================
// Module      : control_contador
// Description : 8-bit up/down counter driven by buttons, with clear, load and
//               press-and-hold auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module control_contador
    import control_contador_pkg::*;
#(
    parameter int P_RETARDO = 16,
    parameter int P_PERIODO = 4
) (
    input  logic               iClk,
    input  logic               iReset_n,
    input  logic               iBtnUp,
    input  logic               iBtnDown,
    input  logic               iBtnClr,
    input  logic               iLoad,
    input  logic [C_ANCHO-1:0] iDato,
    output logic [C_ANCHO-1:0] oCuenta,
    output logic               oOcupado,
    output logic               oDesborde
);

    localparam logic [C_ANCHO-1:0] C_FIN_RETARDO = C_ANCHO'(P_RETARDO - 1);
    localparam logic [C_ANCHO-1:0] C_FIN_PERIODO = C_ANCHO'(P_PERIODO - 1);

    logic [C_NUM_BTN-1:0] w_boton;
    logic [C_NUM_BTN-1:0] w_nivel;
    logic [C_NUM_BTN-1:0] w_flanco;

    assign w_boton[C_BTN_UP]   = iBtnUp;
    assign w_boton[C_BTN_DOWN] = iBtnDown;
    assign w_boton[C_BTN_CLR]  = iBtnClr;
    assign w_boton[C_BTN_LOAD] = iLoad;

    generate
        for (genvar i = 0; i < C_NUM_BTN; i++) begin : g_sync
            flanco_sync u_sync (
                .iClk    (iClk),
                .iReset_n(iReset_n),
                .iBoton  (w_boton[i]),
                .oNivel  (w_nivel[i]),
                .oFlanco (w_flanco[i])
            );
        end
    endgenerate

    // Clear/load only act on their edge; their levels have no consumer
    logic w_unusedNivel;
    assign w_unusedNivel = w_nivel[C_BTN_CLR] ^ w_nivel[C_BTN_LOAD];

    estado_t            r_estado, w_estadoSig;
    dir_t               r_dir, w_dirSig;
    logic [C_ANCHO-1:0] r_cnt, w_cntSig;
    logic [C_ANCHO-1:0] r_cuenta, w_cuentaSig;
    logic               r_desborde, w_desbordeSig;
    logic               r_ocupado;
    logic               w_paso;
    logic               w_nivelDir;
    logic [1:0]         w_prio;

    assign w_prio     = f_arbitra(w_flanco[C_BTN_CLR], w_flanco[C_BTN_LOAD],
                                  w_flanco[C_BTN_UP] | w_flanco[C_BTN_DOWN]);
    assign w_nivelDir = (r_dir == DIR_UP) ? w_nivel[C_BTN_UP] : w_nivel[C_BTN_DOWN];

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_estado   <= ST_IDLE;
            r_dir      <= DIR_UP;
            r_cnt      <= '0;
            r_cuenta   <= '0;
            r_desborde <= 1'b0;
            r_ocupado  <= 1'b0;
        end else begin
            r_estado   <= w_estadoSig;
            r_dir      <= w_dirSig;
            r_cnt      <= w_cntSig;
            r_cuenta   <= w_cuentaSig;
            r_desborde <= w_desbordeSig;
            r_ocupado  <= (w_estadoSig != ST_IDLE);
        end
    end

    always_comb begin
        w_estadoSig   = r_estado;
        w_dirSig      = r_dir;
        w_cntSig      = r_cnt;
        w_cuentaSig   = r_cuenta;
        w_desbordeSig = 1'b0;
        w_paso        = 1'b0;

        if (w_prio == C_PRIO_CLR) begin
            w_cuentaSig = '0;
            w_estadoSig = ST_IDLE;
            w_cntSig    = '0;
        end else if (w_prio == C_PRIO_LOAD) begin
            w_cuentaSig = iDato;
            w_estadoSig = ST_IDLE;
            w_cntSig    = '0;
        end else begin
            case (r_estado)
                ST_IDLE: begin
                    // Up and down together cancel out
                    if (w_flanco[C_BTN_UP] ^ w_flanco[C_BTN_DOWN]) begin
                        w_paso      = 1'b1;
                        w_dirSig    = w_flanco[C_BTN_DOWN] ? DIR_DOWN : DIR_UP;
                        w_cntSig    = '0;
                        w_estadoSig = ST_ESPERA;
                    end
                end
                ST_ESPERA: begin
                    if (!w_nivelDir) begin
                        w_estadoSig = ST_IDLE;
                        w_cntSig    = '0;
                    end else if (r_cnt == C_FIN_RETARDO) begin
                        w_paso      = 1'b1;
                        w_cntSig    = '0;
                        w_estadoSig = ST_REPITE;
                    end else begin
                        w_cntSig = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
                    end
                end
                ST_REPITE: begin
                    if (!w_nivelDir) begin
                        w_estadoSig = ST_IDLE;
                        w_cntSig    = '0;
                    end else if (r_cnt == C_FIN_PERIODO) begin
                        w_paso   = 1'b1;
                        w_cntSig = '0;
                    end else begin
                        w_cntSig = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_estadoSig = ST_IDLE;
                    w_cntSig    = '0;
                end
            endcase

            // The ninth bit is the carry out (up) or borrow out (down)
            if (w_paso) begin
                if (w_dirSig == DIR_UP)
                    {w_desbordeSig, w_cuentaSig} = {1'b0, r_cuenta} + 9'd1;
                else
                    {w_desbordeSig, w_cuentaSig} = {1'b0, r_cuenta} - 9'd1;
            end
        end
    end

    assign oCuenta   = r_cuenta;
    assign oOcupado  = r_ocupado;
    assign oDesborde = r_desborde;

endmodule
`default_nettype wire
